// File: rtl/spidergon_flit_injector.sv
// Spidergon packet injector: accepts one packet request at a time, picks a
// virtual channel by the dateline rule, and launches head/body/tail flits
// under per-VC credit flow control. No back-pressure on the flit output.
module spidergon_flit_injector #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int NODE_ID                 = 0,
    parameter int PKT_LEN                 = 4,
    parameter int VC_DEPTH                = 2,
    localparam int DEST_W                 = $clog2(NUM_OF_NODES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       req_valid,
    input  logic [DEST_W-1:0]          req_dest,
    output logic                       req_ready,
    input  logic [1:0]                 credit_in,
    output logic                       flit_valid,
    output logic [1:0]                 flit_type,
    output logic                       flit_vc,
    output logic [FLIT_DATA_WIDTH-1:0] flit_data,
    output logic [15:0]                pkt_count,
    output logic                       err_self,
    output logic                       credit_err
);

    localparam int                CRED_W   = $clog2(VC_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_DEPTH);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_e;

    state_e                          state_q, state_d;
    logic [DEST_W-1:0]               dest_q, dest_d;
    logic                            vc_q, vc_d;
    logic [7:0]                      idx_q, idx_d;
    logic [15:0]                     pkt_count_q, pkt_count_d;
    logic                            err_self_q, err_self_d;
    logic                            credit_err_q, credit_err_d;
    logic [1:0][CRED_W-1:0]          credit_q, credit_d;
    logic                            flit_valid_q, flit_valid_d;
    logic [1:0]                      flit_type_q, flit_type_d;
    logic                            flit_vc_q, flit_vc_d;
    logic [FLIT_DATA_WIDTH-1:0]      flit_data_q, flit_data_d;

    logic                            accept;
    logic                            launch;
    logic                            dest_bad;
    logic [FLIT_DATA_WIDTH-1:0]      head_data;
    logic [FLIT_DATA_WIDTH-1:0]      body_data;

    assign req_ready = (state_q == IDLE) & en & reset;
    assign accept    = req_valid & req_ready;
    assign launch    = (state_q != IDLE) && (credit_q[vc_q] != '0);
    assign dest_bad  = (int'(req_dest) == NODE_ID) || (int'(req_dest) >= NUM_OF_NODES);

    // Payload formats: head carries source/destination, body/tail carry the
    // packet sequence number and the flit index within the packet.
    always_comb begin
        head_data      = '0;
        head_data[5:3] = 3'(NODE_ID);
        head_data[2:0] = 3'(dest_q);
        body_data      = (FLIT_DATA_WIDTH'(pkt_count_q) << 8) | FLIT_DATA_WIDTH'(idx_q);
    end

    // Next-state logic for the packet FSM, flit registers, credits and flags.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
        state_d      = state_q;
        dest_d       = dest_q;
        vc_d         = vc_q;
        idx_d        = idx_q;
        pkt_count_d  = pkt_count_q;
        err_self_d   = err_self_q;
        credit_err_d = credit_err_q;
        credit_d     = credit_q;
        flit_valid_d = launch;
        flit_vc_d    = launch ? vc_q : 1'b0;
        flit_type_d  = 2'b00;
        flit_data_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dest_bad) begin
                        err_self_d = 1'b1;
                    end else begin
                        dest_d  = req_dest;
                        vc_d    = (int'(req_dest) > NODE_ID) ? 1'b0 : 1'b1;
                        state_d = HEAD;
                    end
                end
            end
            HEAD: begin
                if (launch) begin
                    flit_type_d = 2'b01;
                    flit_data_d = head_data;
                    idx_d       = 8'd1;
                    state_d     = (PKT_LEN == 2) ? TAIL : BODY;
                end
            end
            BODY: begin
                if (launch) begin
                    flit_type_d = 2'b10;
                    flit_data_d = body_data;
                    idx_d       = idx_q + 8'd1;
                    if (idx_q == 8'(PKT_LEN - 2)) state_d = TAIL;
                end
            end
            TAIL: begin
                if (launch) begin
                    flit_type_d = 2'b11;
                    flit_data_d = body_data;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A launch and a returning credit on the same VC cancel out.
        for (int v = 0; v < 2; v++) begin
            if (launch && (vc_q == 1'(v)) && !credit_in[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (credit_in[v] && !(launch && (vc_q == 1'(v)))) begin
                if (credit_q[v] == CRED_MAX) credit_err_d = 1'b1;
                else                          credit_d[v]  = credit_q[v] + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath, credit and flag registers; reset discards any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_q       <= '0;
            vc_q         <= 1'b0;
            idx_q        <= '0;
            pkt_count_q  <= '0;
            err_self_q   <= 1'b0;
            credit_err_q <= 1'b0;
            credit_q     <= {2{CRED_MAX}};
            flit_valid_q <= 1'b0;
            flit_type_q  <= 2'b00;
            flit_vc_q    <= 1'b0;
            flit_data_q  <= '0;
        end else begin
            dest_q       <= dest_d;
            vc_q         <= vc_d;
            idx_q        <= idx_d;
            pkt_count_q  <= pkt_count_d;
            err_self_q   <= err_self_d;
            credit_err_q <= credit_err_d;
            credit_q     <= credit_d;
            flit_valid_q <= flit_valid_d;
            flit_type_q  <= flit_type_d;
            flit_vc_q    <= flit_vc_d;
            flit_data_q  <= flit_data_d;
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_type  = flit_type_q;
    assign flit_vc    = flit_vc_q;
    assign flit_data  = flit_data_q;
    assign pkt_count  = pkt_count_q;
    assign err_self   = err_self_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_spidergon_flit_injector.sv
// Directed bench for spidergon_flit_injector with NODE_ID=2, PKT_LEN=4,
// VC_DEPTH=2. Inputs change and outputs are sampled on the falling edge.
module tb_spidergon_flit_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        req_valid;
    logic [2:0]  req_dest;
    logic        req_ready;
    logic [1:0]  credit_in;
    logic        flit_valid;
    logic [1:0]  flit_type;
    logic        flit_vc;
    logic [15:0] flit_data;
    logic [15:0] pkt_count;
    logic        err_self;
    logic        credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    spidergon_flit_injector #(
        .NUM_OF_NODES(8), .FLIT_DATA_WIDTH(16), .NUM_OF_VIRTUAL_CHANNELS(2),
        .NODE_ID(2), .PKT_LEN(4), .VC_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .req_valid(req_valid),
        .req_dest(req_dest), .req_ready(req_ready), .credit_in(credit_in),
        .flit_valid(flit_valid), .flit_type(flit_type), .flit_vc(flit_vc),
        .flit_data(flit_data), .pkt_count(pkt_count), .err_self(err_self),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; req_valid = 1'b0; req_dest = '0; credit_in = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", flit_valid); end
        n_checks++; if (flit_type !== 2'b00) begin n_fail++; $display("FAIL rst_type got %0b want 00", flit_type); end
        n_checks++; if (flit_vc !== 1'b0) begin n_fail++; $display("FAIL rst_vc got %0b want 0", flit_vc); end
        n_checks++; if (flit_data !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0000", flit_data); end
        n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
        n_checks++; if (err_self !== 1'b0) begin n_fail++; $display("FAIL rst_err_self got %0b want 0", err_self); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_credit_err got %0b want 0", credit_err); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %0b want 0", req_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_req_ready got %0b want 1", req_ready); end
        n_checks++; if (dut.credit_q[0] !== 2) begin n_fail++; $display("FAIL rel_credit0 got %0d want 2", dut.credit_q[0]); end
        n_checks++; if (dut.credit_q[1] !== 2) begin n_fail++; $display("FAIL rel_credit1 got %0d want 2", dut.credit_q[1]); end
    endtask

    // dest 0 <= NODE_ID -> VC 1; credits returned every launch cycle.
    task automatic test_vc1_packet();
        logic [1:0]  exp_type [4];
        logic [15:0] exp_data [4];
        exp_type = '{2'b01, 2'b10, 2'b10, 2'b11};
        exp_data = '{16'h0010, 16'h0001, 16'h0002, 16'h0003};
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL vc1_ready got %0b want 1", req_ready); end
        req_valid = 1'b1; req_dest = 3'd0;
        @(negedge clk);
        req_valid = 1'b0; credit_in = 2'b10;
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL vc1_accept_valid got %0b want 0", flit_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (flit_valid !== 1'b1) begin n_fail++; $display("FAIL vc1_valid[%0d] got %0b want 1", i, flit_valid); end
            n_checks++; if (flit_type !== exp_type[i]) begin n_fail++; $display("FAIL vc1_type[%0d] got %0b want %0b", i, flit_type, exp_type[i]); end
            n_checks++; if (flit_vc !== 1'b1) begin n_fail++; $display("FAIL vc1_vc[%0d] got %0b want 1", i, flit_vc); end
            n_checks++; if (flit_data !== exp_data[i]) begin n_fail++; $display("FAIL vc1_data[%0d] got %h want %h", i, flit_data, exp_data[i]); end
        end
        credit_in = 2'b00;
        n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL vc1_pkt_count got %0d want 1", pkt_count); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL vc1_ready_after got %0b want 1", req_ready); end
        n_checks++; if (dut.credit_q[1] !== 2) begin n_fail++; $display("FAIL vc1_credit got %0d want 2", dut.credit_q[1]); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL vc1_credit_err got %0b want 0", credit_err); end
    endtask

    // dest 5 > NODE_ID -> VC 0; credits run out after two flits.
    task automatic test_credit_stall();
        @(negedge clk);
        req_valid = 1'b1; req_dest = 3'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({flit_valid, flit_type, flit_vc} !== 4'b1010) begin n_fail++; $display("FAIL cs_head_ctl got %b want 1010", {flit_valid, flit_type, flit_vc}); end
        n_checks++; if (flit_data !== 16'h0015) begin n_fail++; $display("FAIL cs_head_data got %h want 0015", flit_data); end
        @(negedge clk);
        n_checks++; if ({flit_valid, flit_type, flit_vc} !== 4'b1100) begin n_fail++; $display("FAIL cs_body1_ctl got %b want 1100", {flit_valid, flit_type, flit_vc}); end
        n_checks++; if (flit_data !== 16'h0101) begin n_fail++; $display("FAIL cs_body1_data got %h want 0101", flit_data); end
        @(negedge clk);
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL cs_stall1 got %0b want 0", flit_valid); end
        @(negedge clk);
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL cs_stall2 got %0b want 0", flit_valid); end
        credit_in = 2'b01;
        @(negedge clk);
        credit_in = 2'b00;
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL cs_stall3 got %0b want 0", flit_valid); end
        @(negedge clk);
        n_checks++; if ({flit_valid, flit_type, flit_vc} !== 4'b1100) begin n_fail++; $display("FAIL cs_body2_ctl got %b want 1100", {flit_valid, flit_type, flit_vc}); end
        n_checks++; if (flit_data !== 16'h0102) begin n_fail++; $display("FAIL cs_body2_data got %h want 0102", flit_data); end
        @(negedge clk);
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL cs_stall4 got %0b want 0", flit_valid); end
        credit_in = 2'b01;
        @(negedge clk);
        credit_in = 2'b00;
        @(negedge clk);
        n_checks++; if ({flit_valid, flit_type, flit_vc} !== 4'b1110) begin n_fail++; $display("FAIL cs_tail_ctl got %b want 1110", {flit_valid, flit_type, flit_vc}); end
        n_checks++; if (flit_data !== 16'h0103) begin n_fail++; $display("FAIL cs_tail_data got %h want 0103", flit_data); end
        n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL cs_pkt_count got %0d want 2", pkt_count); end
        credit_in = 2'b01;
        repeat (2) @(negedge clk);
        credit_in = 2'b00;
        n_checks++; if (dut.credit_q[0] !== 2) begin n_fail++; $display("FAIL cs_credit0 got %0d want 2", dut.credit_q[0]); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL cs_credit_err got %0b want 0", credit_err); end
    endtask

    // en low blocks acceptance; dest == NODE_ID is rejected with err_self.
    task automatic test_self_dest();
        @(negedge clk);
        en = 1'b0; req_valid = 1'b1; req_dest = 3'd2;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL self_en_low_ready got %0b want 0", req_ready); end
        en = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (err_self !== 1'b1) begin n_fail++; $display("FAIL self_err got %0b want 1", err_self); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL self_ready got %0b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL self_valid[%0d] got %0b want 0", i, flit_valid); end
            @(negedge clk);
        end
        n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL self_pkt_count got %0d want 2", pkt_count); end
    endtask

    task automatic test_credit_overflow();
        @(negedge clk);
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %0b want 0", credit_err); end
        credit_in = 2'b10;
        @(negedge clk);
        credit_in = 2'b00;
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %0b want 1", credit_err); end
        n_checks++; if (dut.credit_q[1] !== 2) begin n_fail++; $display("FAIL ovf_credit got %0d want 2", dut.credit_q[1]); end
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        req_valid = 1'b1; req_dest = 3'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (flit_type !== 2'b01) begin n_fail++; $display("FAIL rmp_head got %0b want 01", flit_type); end
        @(negedge clk);
        n_checks++; if ({flit_valid, flit_type} !== 3'b110) begin n_fail++; $display("FAIL rmp_body got %b want 110", {flit_valid, flit_type}); end
        reset = 1'b0;
        #1;
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_valid_now got %0b want 0", flit_valid); end
        n_checks++; if ({flit_type, flit_data} !== 18'h0) begin n_fail++; $display("FAIL rmp_flit_clear got %h want 0", {flit_type, flit_data}); end
        n_checks++; if ({err_self, credit_err, pkt_count} !== 18'h0) begin n_fail++; $display("FAIL rmp_status got %h want 0", {err_self, credit_err, pkt_count}); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_no_tail[%0d] got %0b want 0", i, flit_valid); end
        end
        n_checks++; if (dut.credit_q[0] !== 2) begin n_fail++; $display("FAIL rmp_credit0 got %0d want 2", dut.credit_q[0]); end
        n_checks++; if (dut.credit_q[1] !== 2) begin n_fail++; $display("FAIL rmp_credit1 got %0d want 2", dut.credit_q[1]); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmp_ready got %0b want 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_vc1_packet();
        test_credit_stall();
        test_self_dest();
        test_credit_overflow();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spidergon_flit_injector.md
SPIDERGON_FLIT_INJECTOR -- requirements
Module: spidergon_flit_injector

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 8, number of Spidergon nodes.
REQ-002 SHALL have parameter FLIT_DATA_WIDTH, default 16, flit payload width; minimum 16.
REQ-003 SHALL have parameter NUM_OF_VIRTUAL_CHANNELS, default 2; fixed at 2.
REQ-004 SHALL have parameter NODE_ID, default 0, local node index.
REQ-005 SHALL have parameter PKT_LEN, default 4, flits per packet; minimum 2.
REQ-006 SHALL have parameter VC_DEPTH, default 2, downstream flit slots per VC, used as initial credits.
REQ-007 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port en  input  1  permits acceptance of new requests.
REQ-010 SHALL have port req_valid  input  1  packet request present.
REQ-011 SHALL have port req_dest  input  clog2(NUM_OF_NODES)  destination node.
REQ-012 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-013 SHALL have port credit_in  input  2  one-cycle pulse per VC; each pulse returns one credit.
REQ-014 SHALL have port flit_valid  output  1  flit present this cycle; no back-pressure.
REQ-015 SHALL have port flit_type  output  2  01 head, 10 body, 11 tail, 00 idle.
REQ-016 SHALL have port flit_vc  output  1  VC carrying the flit.
REQ-017 SHALL have port flit_data  output  FLIT_DATA_WIDTH  flit payload.
REQ-018 SHALL have ports pkt_count  output  16  packets completed, and err_self / credit_err  output  1 each  sticky error flags.

Function
REQ-019 SHALL implement FSM IDLE, HEAD, BODY, TAIL.
REQ-020 SHALL drive req_ready = (state==IDLE) & en & reset, combinationally.
REQ-021 On accept, SHALL register req_dest and select VC: 0 when dest > NODE_ID, otherwise 1 (dateline rule); the VC is held for the whole packet.
REQ-022 On accept with dest == NODE_ID or dest >= NUM_OF_NODES, SHALL emit no flits, set err_self, and remain in IDLE.
REQ-023 SHALL keep a credit counter per VC, reset to VC_DEPTH: decrement on launch, increment on credit_in, unchanged when both occur in the same cycle.
REQ-024 A credit_in pulse with the counter already at VC_DEPTH and no same-cycle launch SHALL be ignored and SHALL set credit_err.
REQ-025 In HEAD/BODY/TAIL, a flit SHALL launch only in a cycle where the held VC's credit is > 0; the flit registers load at that edge, so flit_valid is high for exactly the following cycle.
REQ-026 With zero credit, the FSM SHALL stall and flit_valid SHALL be 0.
REQ-027 Head flit_data SHALL be {zero pad, NODE_ID[2:0], dest[2:0]} in bits [5:0].
REQ-028 Body/tail flit_data SHALL be {pkt_count[FLIT_DATA_WIDTH-9:0], flit_index[7:0]}; flit_index runs 1..PKT_LEN-1.
REQ-029 Transitions SHALL be: IDLE->HEAD on accept; HEAD->BODY on launch, or HEAD->TAIL when PKT_LEN==2; BODY->TAIL after PKT_LEN-2 body launches; TAIL->IDLE on launch, with pkt_count incremented (wrapping at 2^16).
REQ-030 Latency SHALL be: accept at edge T with credit available gives the head flit visible in cycle T+1; subsequent flits follow each cycle while credit lasts; there is a one-cycle minimum IDLE gap between packets.
REQ-031 Deasserting en mid-packet SHALL NOT abort the packet; only new acceptance is blocked.

Reset
REQ-032 While reset=0, SHALL asynchronously force: state IDLE, flit_valid 0, flit_type 00, flit_vc 0, flit_data 0, pkt_count 0, err_self 0, credit_err 0, credits = VC_DEPTH, req_ready 0.
REQ-033 Reset asserted mid-packet SHALL discard the packet; no tail is emitted after release.

Verification
REQ-034 Reset: hold reset=0 -> all outputs zero; after release with en=1, req_ready=1 and both credits read 2.
REQ-035 NODE_ID=2, PKT_LEN=4, VC_DEPTH=2, req_dest=5, no credit returns -> head (vc 0, data 0x0015) then body idx1, then flit_valid=0 stall; credit_in[0] pulse at cycle C -> body idx2 at C+2.
REQ-036 req_dest=0 with ample credits -> 4 consecutive flits on vc 1 (types 01,10,10,11), pkt_count 0->1, req_ready high again the cycle after the tail launch.
REQ-037 req_dest=2 (self) -> no flit_valid, err_self=1, pkt_count unchanged.
REQ-038 credit_in[1] pulse with credit already at 2 and no launch -> credit_err=1, credit stays 2.
REQ-039 Assert reset during the body flit -> flit_valid=0 immediately; after release no tail appears and credits=2.
